vsreg_file_sb: RTL

- Next-generation vector/scalar register file for the decode stage.
- Parametrised lane count, width and bank depth; two read ports; one write port with per-lane write mask and same-cycle write-to-read bypass.
- Integrated scoreboard tracks in-flight destination registers, so decode can stall on RAW hazards without external logic.

---
 rtl/vsreg_file_sb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vsreg_file_sb.sv
// Vector/scalar register file for decode: two combinational read ports with
// write-to-read bypass, one masked write port, and an in-flight scoreboard
// that flags RAW hazards on each read operand.
module vsreg_file_sb #(
  parameter int REG_WIDTH = 16,
  parameter int VEC_LANES = 4,
  parameter int SEL_BITS  = 4,
  parameter int CNT_BITS  = SEL_BITS + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [SEL_BITS-1:0]                 wr_sel,
  input  logic [VEC_LANES-1:0]                wr_mask,
  input  logic [VEC_LANES-1:0][REG_WIDTH-1:0] wr_data,
  input  logic [SEL_BITS-1:0]                 rd_sel1,
  input  logic [SEL_BITS-1:0]                 rd_sel2,
  output logic [VEC_LANES-1:0][REG_WIDTH-1:0] rd_data1,
  output logic [VEC_LANES-1:0][REG_WIDTH-1:0] rd_data2,
  output logic                                rd_busy1,
  output logic                                rd_busy2,
  input  logic                                rsv_en,
  input  logic [SEL_BITS-1:0]                 rsv_sel,
  output logic [CNT_BITS-1:0]                 busy_count,
  output logic                                sb_err
);

  localparam int IDX_BITS   = SEL_BITS - 1;
  localparam int BANK_DEPTH = 2 ** IDX_BITS;
  localparam int NUM_REGS   = 2 ** SEL_BITS;
  // Scalar entry 0 is hardwired to zero and never tracked.
  localparam logic [SEL_BITS-1:0] ZERO_SEL = {1'b1, {IDX_BITS{1'b0}}};

  // Storage is flop-based because reads must be zero latency.
  logic [VEC_LANES-1:0][REG_WIDTH-1:0] vec_reg  [BANK_DEPTH];
  logic [REG_WIDTH-1:0]                scal_reg [BANK_DEPTH];

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [CNT_BITS-1:0] busy_count_reg;
  logic [CNT_BITS-1:0] busy_count_next;
  logic                sb_err_reg;
  logic                sb_err_next;

  logic                wr_live;
  logic                rsv_live;
  logic [IDX_BITS-1:0] wr_idx;
  logic                wr_scalar;

  // Accesses to the zero entry are dropped entirely, so they can never
  // disturb data, busy bits or the error flag.
  assign wr_live   = wr_en  && (wr_sel  != ZERO_SEL);
  assign rsv_live  = rsv_en && (rsv_sel != ZERO_SEL);
  assign wr_idx    = wr_sel[IDX_BITS-1:0];
  assign wr_scalar = wr_sel[SEL_BITS-1];

  // Register storage update: masked lanes for vectors, lane 0 for scalars.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        vec_reg[i]  <= '0;
        scal_reg[i] <= '0;
      end
    end else if (wr_live) begin
      if (wr_scalar) begin
        scal_reg[wr_idx] <= wr_data[0];
      end else begin
        for (int l = 0; l < VEC_LANES; l++) begin
          if (wr_mask[l]) vec_reg[wr_idx][l] <= wr_data[l];
        end
      end
    end
  end

  // Scoreboard next state: release on write, then reserve (reservation wins).
  always_comb begin
    busy_next   = busy_reg;
    sb_err_next = sb_err_reg;
    if (wr_live) busy_next[wr_sel] = 1'b0;
    if (rsv_live) begin
      busy_next[rsv_sel] = 1'b1;
      // Double reservation is only an error if no write retires it this cycle.
      if (busy_reg[rsv_sel] && !(wr_live && (wr_sel == rsv_sel))) sb_err_next = 1'b1;
    end
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_next = busy_count_next + CNT_BITS'(busy_next[i]);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg       <= '0;
      busy_count_reg <= '0;
      sb_err_reg     <= 1'b0;
    end else begin
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
      sb_err_reg     <= sb_err_next;
    end
  end

  assign busy_count = busy_count_reg;
  assign sb_err     = sb_err_reg;

  // Both read ports share one implementation.
  logic [SEL_BITS-1:0]                 rd_sel_arr  [2];
  logic [VEC_LANES-1:0][REG_WIDTH-1:0] rd_data_arr [2];
  logic                                rd_busy_arr [2];

  assign rd_sel_arr[0] = rd_sel1;
  assign rd_sel_arr[1] = rd_sel2;
  assign rd_data1      = rd_data_arr[0];
  assign rd_data2      = rd_data_arr[1];
  assign rd_busy1      = rd_busy_arr[0];
  assign rd_busy2      = rd_busy_arr[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      logic                 hit;
      logic [IDX_BITS-1:0]  idx;
      logic [REG_WIDTH-1:0] scalar_val;

      assign idx = rd_sel_arr[gi][IDX_BITS-1:0];
      // A live write to the same register bypasses into this port.
      assign hit = wr_live && (wr_sel == rd_sel_arr[gi]);

      // Operand mux with bypass; scalars are broadcast to every lane.
      always_comb begin
        rd_data_arr[gi] = '0;
        scalar_val      = scal_reg[idx];
        if (rd_sel_arr[gi][SEL_BITS-1]) begin
          if (hit) scalar_val = wr_data[0];
          for (int l = 0; l < VEC_LANES; l++) rd_data_arr[gi][l] = scalar_val;
        end else begin
          for (int l = 0; l < VEC_LANES; l++) begin
            rd_data_arr[gi][l] = (hit && wr_mask[l]) ? wr_data[l] : vec_reg[idx][l];
          end
        end
      end

      // A same-cycle write resolves the hazard through the bypass.
      assign rd_busy_arr[gi] = busy_reg[rd_sel_arr[gi]] && !hit;
    end
  endgenerate

endmodule
